uart_cmd_responder: RTL and testbench

Byte-level command responder on the device side of the UART link. It consumes received bytes from the UART receiver's `rx_DV`/`rx_Byte` output, parses host command frames, launches a PUF evaluation with the received challenge, and returns the reply frame byte-by-byte through the UART transmitter's `tx_DV`/`tx_Byte`/`tx_Done` handshake. It sits between `UART_RXD`/`UART_TXD` and the PUF core.

---
 rtl/uart_cmd_responder.sv | 168 ++++++++++++++++
 tb/tb_uart_cmd_responder.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_responder.sv
// Device-side UART command responder: decodes PING / CHALLENGE frames, launches the PUF
// and returns the reply one byte at a time over the transmitter handshake.
module uart_cmd_responder #(
    parameter int unsigned CHAL_BYTES       = 8,
    parameter int unsigned RESP_BYTES       = 4,
    parameter int unsigned RX_TIMEOUT_CLKS  = 20000,
    parameter int unsigned PUF_TIMEOUT_CLKS = 65535
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx_DV,
    input  logic [7:0]              rx_Byte,
    output logic                    tx_DV,
    output logic [7:0]              tx_Byte,
    input  logic                    tx_Active,
    input  logic                    tx_Done,
    output logic [8*CHAL_BYTES-1:0] puf_challenge,
    output logic                    puf_start,
    input  logic                    puf_valid,
    input  logic [8*RESP_BYTES-1:0] puf_response,
    output logic                    busy,
    output logic [7:0]              drop_count
);
    localparam int unsigned ChalW  = 8 * CHAL_BYTES;
    localparam int unsigned ReplyW = 8 * (RESP_BYTES + 1);

    localparam logic [7:0] CmdChal = 8'h3F;
    localparam logic [7:0] CmdPing = 8'hA5;
    localparam logic [7:0] RspPing = 8'h5A;
    localparam logic [7:0] RspErr  = 8'hEE;

    localparam logic [4:0]  LastChal   = 5'(CHAL_BYTES - 1);
    localparam logic [4:0]  ReplyLen   = 5'(RESP_BYTES + 1);
    localparam logic [31:0] RxTmoLast  = 32'(RX_TIMEOUT_CLKS - 1);
    localparam logic [31:0] PufTmoLast = 32'(PUF_TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {StIdle, StGetChal, StPufWait, StTxLoad, StTxWait} state_e;

    state_e            state_q, state_d;
    logic [ChalW-1:0]  chal_q, chal_d;
    logic [ReplyW-1:0] reply_q, reply_d;
    logic [4:0]        byte_cnt_q, byte_cnt_d;
    logic [4:0]        tx_left_q, tx_left_d;
    logic [31:0]       tmo_q, tmo_d;
    logic              tx_dv_q, tx_dv_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              puf_start_q, puf_start_d;
    logic [7:0]        drop_q, drop_d;
    logic [ChalW+7:0]  chal_shift;
    logic              rx_dropped;

    assign chal_shift = {chal_q, rx_Byte};
    assign rx_dropped = rx_DV && (state_q inside {StPufWait, StTxLoad, StTxWait});

    always_comb begin
        state_d     = state_q;
        chal_d      = chal_q;
        reply_d     = reply_q;
        byte_cnt_d  = byte_cnt_q;
        tx_left_d   = tx_left_q;
        tmo_d       = tmo_q;
        tx_dv_d     = 1'b0;
        tx_byte_d   = tx_byte_q;
        puf_start_d = 1'b0;
        drop_d      = drop_q;

        if (rx_dropped && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end

        case (state_q)
            StIdle: begin
                if (rx_DV) begin
                    if (rx_Byte == CmdChal) begin
                        byte_cnt_d = '0;
                        tmo_d      = '0;
                        state_d    = StGetChal;
                    end else begin
                        reply_d   = {(rx_Byte == CmdPing) ? RspPing : RspErr,
                                     {(ReplyW-8){1'b0}}};
                        tx_left_d = 5'd1;
                        state_d   = StTxLoad;
                    end
                end
            end
            StGetChal: begin
                if (rx_DV) begin
                    chal_d = chal_shift[ChalW-1:0];
                    tmo_d  = '0;
                    if (byte_cnt_q == LastChal) begin
                        puf_start_d = 1'b1;
                        state_d     = StPufWait;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 5'd1;
                    end
                end else if (tmo_q == RxTmoLast) begin
                    // Abandoned frame: silently return, partial challenge stays visible.
                    tmo_d   = '0;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            StPufWait: begin
                if (puf_valid) begin
                    reply_d   = {CmdChal, puf_response};
                    tx_left_d = ReplyLen;
                    state_d   = StTxLoad;
                end else if (tmo_q == PufTmoLast) begin
                    reply_d   = {RspErr, {(ReplyW-8){1'b0}}};
                    tx_left_d = 5'd1;
                    state_d   = StTxLoad;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            StTxLoad: begin
                if (!tx_Active) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = reply_q[ReplyW-1 -: 8];
                    reply_d   = reply_q << 8;
                    tx_left_d = tx_left_q - 5'd1;
                    state_d   = StTxWait;
                end
            end
            StTxWait: begin
                if (tx_Done) begin
                    state_d = (tx_left_q != 5'd0) ? StTxLoad : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            chal_q      <= '0;
            reply_q     <= '0;
            byte_cnt_q  <= '0;
            tx_left_q   <= '0;
            tmo_q       <= '0;
            tx_dv_q     <= 1'b0;
            tx_byte_q   <= '0;
            puf_start_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            chal_q      <= chal_d;
            reply_q     <= reply_d;
            byte_cnt_q  <= byte_cnt_d;
            tx_left_q   <= tx_left_d;
            tmo_q       <= tmo_d;
            tx_dv_q     <= tx_dv_d;
            tx_byte_q   <= tx_byte_d;
            puf_start_q <= puf_start_d;
            drop_q      <= drop_d;
        end
    end

    assign tx_DV         = tx_dv_q;
    assign tx_Byte       = tx_byte_q;
    assign puf_challenge = chal_q;
    assign puf_start     = puf_start_q;
    assign busy          = (state_q != StIdle);
    assign drop_count    = drop_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Randomized bench for uart_cmd_responder: UART-TX and PUF behavioural models plus a
// frame-level reply model that predicts every reply byte, challenge and drop count.
module tb_uart_cmd_responder;
    localparam int unsigned CB   = 8;
    localparam int unsigned RB   = 4;
    localparam int unsigned RXT  = 200;
    localparam int unsigned PUFT = 400;

    typedef logic [7:0] u8_t;

    logic            clk = 1'b0;
    logic            rst_n, rx_DV, tx_DV, tx_Active, tx_Done, puf_start, puf_valid, busy;
    logic [7:0]      rx_Byte, tx_Byte, drop_count;
    logic [8*CB-1:0] puf_challenge;
    logic [8*RB-1:0] puf_response;

    uart_cmd_responder #(
        .CHAL_BYTES      (CB),
        .RESP_BYTES      (RB),
        .RX_TIMEOUT_CLKS (RXT),
        .PUF_TIMEOUT_CLKS(PUFT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_DV        (rx_DV),
        .rx_Byte      (rx_Byte),
        .tx_DV        (tx_DV),
        .tx_Byte      (tx_Byte),
        .tx_Active    (tx_Active),
        .tx_Done      (tx_Done),
        .puf_challenge(puf_challenge),
        .puf_start    (puf_start),
        .puf_valid    (puf_valid),
        .puf_response (puf_response),
        .busy         (busy),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed transmit stream
    u8_t got_b[$];
    int  got_c[$];
    bit  got_gap[$];
    int  last_free = 0;

    // PUF model controls and observations
    int          puf_delay;
    logic [31:0] puf_resp;
    int          valid_cyc = 0;
    int          start_cnt = 0;
    int          start_cyc = 0;

    // Reference state
    logic [63:0] exp_chal;
    int          drop_exp;
    u8_t         exp_q[$];
    int          first_rx_cyc, last_rx_cyc, frame_base;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (puf_start) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
        end
    end

    // UART transmitter: random byte time, random extra busy time after tx_Done
    initial begin
        u8_t held;
        int  len, hold;
        bit  abort;
        tx_Active = 1'b0;
        tx_Done   = 1'b0;
        forever begin
            tick(1);
            if (rst_n && tx_DV) begin
                got_b.push_back(tx_Byte);
                got_c.push_back(cyc);
                got_gap.push_back(cyc == last_free + 1);
                held      = tx_Byte;
                tx_Active = 1'b1;
                len       = int'($urandom_range(2, 10));
                abort     = 1'b0;
                for (int i = 0; i < len && !abort; i++) begin
                    tick(1);
                    if (!rst_n) abort = 1'b1;
                    else begin
                        check_eq("tx_dv_while_active", 64'(tx_DV), 64'd0);
                        check_eq("tx_byte_stable", 64'(tx_Byte), 64'(held));
                    end
                end
                if (!abort) begin
                    hold      = int'($urandom_range(0, 3));
                    tx_Done   = 1'b1;
                    tx_Active = (hold != 0);
                    tick(1);
                    tx_Done = 1'b0;
                    for (int j = 0; j < hold; j++) begin
                        if (rst_n) check_eq("tx_dv_during_hold", 64'(tx_DV), 64'd0);
                        tick(1);
                    end
                end
                tx_Active = 1'b0;
                last_free = cyc;
            end
        end
    end

    // PUF: answers puf_delay cycles after puf_start, or never when puf_delay < 0
    initial begin
        puf_valid    = 1'b0;
        puf_response = '0;
        forever begin
            tick(1);
            if (rst_n && puf_start && puf_delay >= 0) begin
                tick(puf_delay);
                puf_valid    = 1'b1;
                puf_response = puf_resp;
                valid_cyc    = cyc;
                tick(1);
                puf_valid    = 1'b0;
                puf_response = $urandom;
            end
        end
    end

    task automatic model_reply(input u8_t frame[$], input bit puf_ok, input logic [31:0] resp);
        exp_q.delete();
        if (frame[0] == 8'hA5) begin
            exp_q.push_back(8'h5A);
        end else if (frame[0] == 8'h3F) begin
            for (int i = 1; i < frame.size(); i++) exp_chal = (exp_chal << 8) | 64'(frame[i]);
            if (puf_ok) begin
                exp_q.push_back(8'h3F);
                for (int i = RB - 1; i >= 0; i--) exp_q.push_back(8'(resp >> (8 * i)));
            end else begin
                exp_q.push_back(8'hEE);
            end
        end else begin
            exp_q.push_back(8'hEE);
        end
    endtask

    task automatic send_byte(input u8_t b, output int at);
        rx_DV   = 1'b1;
        rx_Byte = b;
        at      = cyc;
        tick(1);
        rx_DV   = 1'b0;
        rx_Byte = 8'($urandom);
    endtask

    task automatic send_drops(input int n, input bit spaced);
        for (int i = 0; i < n; i++) begin
            rx_DV   = 1'b1;
            rx_Byte = (i % 3 == 0) ? 8'h3F : ((i % 3 == 1) ? 8'hA5 : 8'($urandom));
            tick(1);
            rx_DV = 1'b0;
            if (spaced) tick(1);
        end
        drop_exp = (drop_exp + n > 255) ? 255 : drop_exp + n;
    endtask

    task automatic run_frame(input u8_t frame[$], input int delay, input logic [31:0] resp,
                             input int gap_max, input int drops_wait, input int drops_tx,
                             input string tag);
        int base, s0, at, n;
        base       = got_b.size();
        frame_base = base;
        s0         = start_cnt;
        puf_delay  = delay;
        puf_resp   = resp;
        model_reply(frame, (delay >= 0 && delay < int'(PUFT)), resp);
        n = exp_q.size();
        at = 0;
        foreach (frame[i]) begin
            if (i > 0) tick(int'($urandom_range(0, gap_max)));
            send_byte(frame[i], at);
            if (i == 0) first_rx_cyc = at;
        end
        last_rx_cyc = at;
        if (drops_wait > 0) begin
            tick(2);
            send_drops(drops_wait, 1'b0);
        end
        if (drops_tx > 0) begin
            for (int i = 0; i < 2000 && got_b.size() <= base; i++) tick(1);
            tick(1);
            send_drops(drops_tx, 1'b1);
        end
        for (int i = 0; i < 3000; i++) begin
            if (got_b.size() >= base + n && !busy) break;
            tick(1);
        end
        tick(3);
        check_eq({tag, "_len"}, 64'(got_b.size() - base), 64'(n));
        for (int i = 0; i < n && base + i < got_b.size(); i++) begin
            check_eq($sformatf("%s_byte%0d", tag, i), 64'(got_b[base+i]), 64'(exp_q[i]));
            if (i > 0) check_eq($sformatf("%s_gap%0d", tag, i), 64'(got_gap[base+i]), 64'd1);
        end
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_drops"}, 64'(drop_count), 64'(drop_exp));
        if (frame[0] == 8'h3F) begin
            check_eq({tag, "_starts"}, 64'(start_cnt - s0), 64'd1);
            check_eq({tag, "_chal"}, puf_challenge, exp_chal);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tx_dv"}, 64'(tx_DV), 64'd0);
        check_eq({tag, "_puf_start"}, 64'(puf_start), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_tx_byte"}, 64'(tx_Byte), 64'd0);
        check_eq({tag, "_chal"}, puf_challenge, 64'd0);
        check_eq({tag, "_drops"}, 64'(drop_count), 64'd0);
    endtask

    task automatic chal_frame(output u8_t fr[$]);
        fr.delete();
        fr.push_back(8'h3F);
        for (int i = 0; i < CB; i++) fr.push_back(8'($urandom));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        u8_t fr[$];
        int  base, s0, at, n0, d, kind, dly, dw;

        rst_n     = 1'b0;
        rx_DV     = 1'b0;
        rx_Byte   = 8'h00;
        puf_delay = -1;
        puf_resp  = '0;
        exp_chal  = '0;
        drop_exp  = 0;
        tick(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(2);

        // PING with latency check
        fr = '{8'hA5};
        run_frame(fr, -1, 32'h0, 0, 0, 0, "ping");
        if (got_c.size() > frame_base)
            check_eq("ping_latency", 64'(got_c[frame_base] - first_rx_cyc), 64'd2);

        // Known challenge vector
        fr = '{8'h3F, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_frame(fr, 10, 32'hDEADBEEF, 0, 0, 0, "chal");
        check_eq("chal_value", puf_challenge, 64'h0102030405060708);
        check_eq("chal_start_latency", 64'(start_cyc - last_rx_cyc), 64'd1);
        if (got_c.size() > frame_base)
            check_eq("chal_resp_latency", 64'(got_c[frame_base] - valid_cyc >= 2), 64'd1);

        fr = '{8'h00};
        run_frame(fr, -1, 32'h0, 0, 0, 0, "unknown");

        // Three strobes while the reply is being transmitted
        chal_frame(fr);
        run_frame(fr, 8, $urandom, 2, 0, 3, "drop3");
        check_eq("drop3_count", 64'(drop_count), 64'd3);

        // No PUF answer plus 300 dropped strobes while waiting
        chal_frame(fr);
        run_frame(fr, -1, 32'h0, 0, 300, 0, "puf_tmo");
        check_eq("drop_saturated", 64'(drop_count), 64'd255);
        if (got_c.size() > frame_base) begin
            d = got_c[frame_base] - start_cyc;
            check_eq("puf_tmo_latency", 64'(d >= int'(PUFT) && d <= int'(PUFT) + 5), 64'd1);
        end

        // PUF answer on the last allowed cycle, and one just too late
        chal_frame(fr);
        run_frame(fr, int'(PUFT) - 1, $urandom, 1, 0, 0, "puf_edge_ok");
        chal_frame(fr);
        run_frame(fr, int'(PUFT) + 1, $urandom, 1, 0, 0, "puf_edge_late");

        // Truncated challenge times out silently
        base = got_b.size();
        s0   = start_cnt;
        send_byte(8'h3F, at);
        send_byte(8'h11, at);
        send_byte(8'h22, at);
        exp_chal = (exp_chal << 16) | 64'h1122;
        tick(int'(RXT) - 10);
        check_eq("rxto_busy_before", 64'(busy), 64'd1);
        tick(11);
        check_eq("rxto_busy_after", 64'(busy), 64'd0);
        check_eq("rxto_no_tx", 64'(got_b.size() - base), 64'd0);
        check_eq("rxto_no_start", 64'(start_cnt - s0), 64'd0);
        check_eq("rxto_partial_chal", puf_challenge, exp_chal);
        fr = '{8'hA5};
        run_frame(fr, -1, 32'h0, 0, 0, 0, "ping_after_rxto");

        // Reset while a challenge reply is in flight
        chal_frame(fr);
        base      = got_b.size();
        puf_delay = 5;
        puf_resp  = $urandom;
        foreach (fr[i]) send_byte(fr[i], at);
        for (int i = 0; i < 500 && got_b.size() < base + 2; i++) tick(1);
        check_eq("rst_reached_tx", 64'(got_b.size() >= base + 2), 64'd1);
        tick(1);
        rst_n = 1'b0;
        tick(1);
        check_reset_outputs("midreset");
        tick(1);
        rst_n    = 1'b1;
        exp_chal = '0;
        drop_exp = 0;
        n0       = got_b.size();
        tick(60);
        check_eq("rst_no_more_tx", 64'(got_b.size()), 64'(n0));
        check_eq("rst_idle", 64'(busy), 64'd0);
        fr = '{8'hA5};
        run_frame(fr, -1, 32'h0, 0, 0, 0, "ping_after_rst");

        // Random frames
        for (int k = 0; k < 25; k++) begin
            kind = int'($urandom_range(0, 7));
            dly  = int'($urandom_range(1, 40));
            dw   = 0;
            fr.delete();
            if (kind == 0) begin
                fr.push_back(8'hA5);
            end else if (kind == 1) begin
                fr.push_back(8'($urandom));
                if (fr[0] == 8'h3F || fr[0] == 8'hA5) fr[0] = 8'h00;
            end else begin
                chal_frame(fr);
                if (kind == 7) dly = -1;
                else if (dly >= 10) dw = int'($urandom_range(1, 5));
            end
            run_frame(fr, dly, $urandom, 4, dw, 0, $sformatf("rand%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
